// File: rtl/round_pkg.sv
// Shared types and defaults for the Genius round counter.
package round_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } round_state_t;

    localparam int ROUND_W = 4;

endpackage

// File: rtl/round_counter_param.sv
// Parametrised round counter: latches a clamped target, advances per E, flags terminal count.
// Optional feature: define ROUND_AUTORELOAD_EN to let E in DONE restart the same round sequence.
module round_counter_param
    import round_pkg::*;
#(
    parameter int WIDTH     = ROUND_W,
    parameter int MAX_ROUND = 15,
    parameter int TC_PULSE  = 0
) (
    input  logic             clk,
    input  logic             R,
    input  logic             LD,
    input  logic [WIDTH-1:0] data,
    input  logic             E,
    output logic [WIDTH-1:0] ROUND,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_ROUND);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    round_state_t     state;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] round_inc;

    assign clamped   = (data > MAX_L) ? MAX_L : data;
    assign round_inc = ROUND + ONE;

    // NOTE: every output is a register updated with <= in this one block, so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
            ROUND <= '0;
            limit <= '0;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else if (LD) begin
            limit <= clamped;
            ROUND <= '0;
            if (clamped == '0) begin
                state <= DONE;
                tc    <= 1'b1;
                busy  <= 1'b0;
            end else begin
                state <= COUNT;
                tc    <= 1'b0;
                busy  <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    tc   <= 1'b0;
                    busy <= 1'b0;
                end
                COUNT: begin
                    if (E) begin
                        ROUND <= round_inc;
                        if (round_inc == limit) begin
                            state <= DONE;
                            tc    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // A pulse-mode flag drops after its single entry cycle.
                    tc <= (TC_PULSE == 0);
`ifdef ROUND_AUTORELOAD_EN
                    if (E) begin
                        if (limit == '0) begin
                            tc <= 1'b1;
                        end else begin
                            state <= COUNT;
                            ROUND <= '0;
                            tc    <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    ROUND <= '0;
                    tc    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_counter_param.sv
// Bench for round_counter_param: level and pulse variants (MAX_ROUND=10) against a count/limit model.
// Honours ROUND_AUTORELOAD_EN when defined for the whole build.
module tb_round_counter_param;

    localparam int W   = 4;
    localparam int MAX = 10;

    logic         clk = 1'b0;
    logic         R   = 1'b1;
    logic         LD  = 1'b0;
    logic [W-1:0] data = '0;
    logic         E   = 1'b0;

    logic [W-1:0] round_a, round_b;
    logic         tc_a, tc_b, busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    round_counter_param #(.WIDTH(W), .MAX_ROUND(MAX), .TC_PULSE(0)) dut_lvl (
        .clk(clk), .R(R), .LD(LD), .data(data), .E(E),
        .ROUND(round_a), .tc(tc_a), .busy(busy_a)
    );

    round_counter_param #(.WIDTH(W), .MAX_ROUND(MAX), .TC_PULSE(1)) dut_pls (
        .clk(clk), .R(R), .LD(LD), .data(data), .E(E),
        .ROUND(round_b), .tc(tc_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Model: rounds accepted since the last load, the clamped limit, and whether the
    // last edge produced a terminal event (reaching the limit, or loading/re-pulsing limit 0).
    bit m_loaded = 1'b0;
    int m_cnt    = 0;
    int m_lim    = 0;
    bit m_pulse  = 1'b0;
    bit started  = 1'b0;

    always @(posedge clk) begin
        if (R) begin
            m_loaded = 1'b0;
            m_cnt    = 0;
            m_lim    = 0;
            m_pulse  = 1'b0;
            started  = 1'b1;
        end else if (LD) begin
            m_loaded = 1'b1;
            m_lim    = (int'(data) > MAX) ? MAX : int'(data);
            m_cnt    = 0;
            m_pulse  = (m_lim == 0);
        end else if (m_loaded && E) begin
            if (m_cnt < m_lim) begin
                m_cnt   = m_cnt + 1;
                m_pulse = (m_cnt == m_lim);
            end else begin
`ifdef ROUND_AUTORELOAD_EN
                m_pulse = (m_lim == 0);
                m_cnt   = 0;
`else
                m_pulse = 1'b0;
`endif
            end
        end else begin
            m_pulse = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("round_lvl", 32'(round_a), 32'(m_cnt));
            check("round_pls", 32'(round_b), 32'(m_cnt));
            check("busy_lvl",  32'(busy_a),  32'(m_loaded && m_cnt < m_lim));
            check("busy_pls",  32'(busy_b),  32'(m_loaded && m_cnt < m_lim));
            check("tc_lvl",    32'(tc_a),    32'(m_loaded && m_cnt == m_lim));
            check("tc_pls",    32'(tc_b),    32'(m_pulse));
        end
    end

    // Apply one cycle of inputs; returns just after the edge that consumes them.
    task automatic step(input bit r, input bit ld, input int d, input bit e);
        @(negedge clk);
        R    = r;
        LD   = ld;
        data = W'(d);
        E    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int rnd, input bit tcl, input bit tcp, input bit bsy);
        check({tag, "_round"}, 32'(round_a), 32'(rnd));
        check({tag, "_tcl"},   32'(tc_a),    32'(tcl));
        check({tag, "_tcp"},   32'(tc_b),    32'(tcp));
        check({tag, "_busy"},  32'(busy_a),  32'(bsy));
    endtask

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_out("reset", 0, 0, 0, 0);

        // E without a load is ignored.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            expect_out("idle_e", 0, 0, 0, 0);
        end

        // Load 4, advance with gaps.
        step(0, 1, 4, 0);
        expect_out("ld4", 0, 0, 0, 1);
        step(0, 0, 0, 1); expect_out("r1", 1, 0, 0, 1);
        step(0, 0, 0, 0); expect_out("gap", 1, 0, 0, 1);
        step(0, 0, 0, 1); expect_out("r2", 2, 0, 0, 1);
        step(0, 0, 0, 1); expect_out("r3", 3, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1); expect_out("r4", 4, 1, 1, 0);
        step(0, 0, 0, 0); expect_out("done_hold", 4, 1, 0, 0);
`ifndef ROUND_AUTORELOAD_EN
        step(0, 0, 0, 1); expect_out("e5", 4, 1, 0, 0);
`endif

        // Clamp: 15 becomes 10.
        step(0, 1, 15, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
        expect_out("clamp9", 9, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("clamp10", 10, 1, 1, 0);
`ifndef ROUND_AUTORELOAD_EN
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("clamp12", 10, 1, 0, 0);
`endif

        // Zero limit goes straight to DONE.
        step(0, 1, 0, 0);
        expect_out("ld0", 0, 1, 1, 0);
        step(0, 0, 0, 0);
        expect_out("ld0_next", 0, 1, 0, 0);

        // LD beats E mid-count, then reset mid-count.
        step(0, 1, 5, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("mid2", 2, 0, 0, 1);
        step(0, 1, 3, 1);
        expect_out("ld_e", 0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("mid1", 1, 0, 0, 1);
        step(1, 0, 0, 1);
        expect_out("rst_mid", 0, 0, 0, 0);
        step(0, 0, 0, 1);
        expect_out("rst_idle", 0, 0, 0, 0);

`ifdef ROUND_AUTORELOAD_EN
        step(0, 1, 2, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("ar_done", 2, 1, 1, 0);
        step(0, 0, 0, 1);
        expect_out("ar_reload", 0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        expect_out("ar_done2", 2, 1, 1, 0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 8),
                 int'($urandom_range(15)), ($urandom_range(1) == 1));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/round_counter_param.md
# round_counter_param

Parametrised round counter for the Genius game datapath, successor of the fixed 4-bit round counter. It latches a target round count, advances one round per enable pulse, and flags terminal count when the target is reached. A three-state FSM (IDLE/COUNT/DONE) defines the behaviour, with a compile-time limit clamp and a selectable pulse or level terminal flag. It sits between the game controller FSM, which drives load and advance, and the sequence memory addressing and display logic, which consume ROUND.

## Interface
- WIDTH, 4: width of ROUND, data and the internal limit register.
- MAX_ROUND, 15: largest accepted limit. Must satisfy 1 ≤ MAX_ROUND ≤ 2^WIDTH−1.
- TC_PULSE, 0: 0 makes tc a level held while in DONE. 1 makes tc a one-cycle pulse on entry to DONE.

Ports:
- clk  in  1  single clock, rising edge.
- R  in  1  reset, synchronous, active-high.
- LD  in  1  load target from data, clear count, start counting.
- data  in  WIDTH  target round count, sampled only when LD=1.
- E  in  1  advance one round.
- ROUND  out  WIDTH  current round, registered.
- tc  out  1  terminal count.
- busy  out  1  high while in COUNT.

## Operation
- State IDLE (after reset): E ignored; ROUND=0; tc=0; busy=0.
- LD in any state: limit ← min(data, MAX_ROUND); ROUND ← 0.
  - If the clamped limit = 0, go to DONE.
  - Otherwise go to COUNT.
- COUNT with E=1: ROUND ← ROUND+1. If ROUND+1 = limit, go to DONE.
- COUNT with E=0: hold.
- DONE: ROUND holds at limit. E is ignored unless ROUND_AUTORELOAD_EN is defined (see Configuration).
- Priority: R > LD > E. If LD and E are both high in the same cycle, LD is applied and E is dropped.
- Arithmetic: ROUND never exceeds limit ≤ MAX_ROUND, so the increment cannot overflow WIDTH and no wrap-around occurs.
- tc:
  - TC_PULSE=0: tc = (state==DONE).
  - TC_PULSE=1: tc=1 only in the first cycle after entering DONE, including entry via LD with limit 0.
- busy = (state==COUNT).

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset: R=1 at an edge gives, from the next cycle, state=IDLE, ROUND=0, limit=0, tc=0, busy=0. This holds mid-count and in DONE.
- LD at edge n: ROUND=0 and busy=1 visible in cycle n+1. If the clamped limit is 0, tc=1 and busy=0 in cycle n+1 instead.
- E at edge n: the new ROUND is visible in cycle n+1. On the final E, ROUND=limit, tc=1 and busy=0 all appear in the same cycle n+1.
- Rounds to completion: exactly limit E pulses after LD. Gaps between E pulses are allowed.

## Configuration
- ROUND_AUTORELOAD_EN defined: in DONE, E=1 sets ROUND ← 0 and returns to COUNT with limit retained. With TC_PULSE=0, tc deasserts in the next cycle. If limit=0, E in DONE keeps ROUND=0 and stays in DONE, re-pulsing tc when TC_PULSE=1.
- ROUND_AUTORELOAD_EN undefined: E in DONE has no effect, and only LD or R leave DONE.

## Structure
- Package round_pkg holds:
  - the state typedef round_state_t with IDLE=2'b00, COUNT=2'b01, DONE=2'b10;
  - the default width constant ROUND_W=4.
- No sub-module. The FSM, limit register, clamp and counter fit in one module. The clamp is inline combinational logic on data.

## Test plan
- Reset, then E=1 for 3 cycles with no LD → ROUND=0, tc=0, busy=0 throughout.
- LD with data=4, then 4 E pulses with gaps → ROUND steps 1,2,3,4; tc=1 and busy=0 in the cycle ROUND=4; a 5th E leaves ROUND=4.
- MAX_ROUND=10, LD with data=15, then 12 E pulses → ROUND stops at 10 and tc rises after the 10th E.
- LD with data=0 → next cycle ROUND=0, tc=1, busy=0. With TC_PULSE=1, tc is high for exactly 1 cycle.
- Mid-count at ROUND=2 with limit=5, LD=1 and E=1 together with data=3 → ROUND=0, limit=3. Then R=1 at ROUND=1 → ROUND=0 and state IDLE next cycle.
- ROUND_AUTORELOAD_EN defined, limit=2, reach DONE, then E=1 → ROUND=0, busy=1, tc=0. Two more E pulses → DONE again.
